// File: rtl/calc_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : calc_req_arbiter
// Description : Four-port two-beat calc request collector. It issues onto a
//               shared downstream port and routes tagged responses back to
//               the requesting port. Fixed-priority arbitration replaces
//               round-robin when CALC_ARB_FIXED_PRIORITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module calc_req_arbiter (
  input  logic        c_clk,
  input  logic        reset,
  input  logic [3:0]  req1_cmd_in,
  input  logic [3:0]  req2_cmd_in,
  input  logic [3:0]  req3_cmd_in,
  input  logic [3:0]  req4_cmd_in,
  input  logic [31:0] req1_data_in,
  input  logic [31:0] req2_data_in,
  input  logic [31:0] req3_data_in,
  input  logic [31:0] req4_data_in,
  input  logic [1:0]  req1_tag_in,
  input  logic [1:0]  req2_tag_in,
  input  logic [1:0]  req3_tag_in,
  input  logic [1:0]  req4_tag_in,
  output logic        port1_busy,
  output logic        port2_busy,
  output logic        port3_busy,
  output logic        port4_busy,
  output logic [1:0]  out_resp1,
  output logic [1:0]  out_resp2,
  output logic [1:0]  out_resp3,
  output logic [1:0]  out_resp4,
  output logic [31:0] out_data1,
  output logic [31:0] out_data2,
  output logic [31:0] out_data3,
  output logic [31:0] out_data4,
  output logic [1:0]  out_tag1,
  output logic [1:0]  out_tag2,
  output logic [1:0]  out_tag3,
  output logic [1:0]  out_tag4,
  output logic [3:0]  dn_cmd,
  output logic [31:0] dn_data,
  output logic [1:0]  dn_tag,
  input  logic [1:0]  dn_resp,
  input  logic [31:0] dn_rdata,
  input  logic [1:0]  dn_rtag
);

  typedef enum logic [1:0] {SLOT_EMPTY, SLOT_OP2, SLOT_PEND, SLOT_OUT} slot_t;
  typedef enum logic [1:0] {ISS_IDLE, ISS_ISSUE1, ISS_ISSUE2} iss_t;

  logic [3:0]  w_req_cmd  [4];
  logic [31:0] w_req_data [4];
  logic [1:0]  w_req_tag  [4];

  slot_t       r_slot     [4];
  slot_t       w_slot_nxt [4];
  logic [3:0]  r_cmd      [4];
  logic [31:0] r_op1      [4];
  logic [31:0] r_op2      [4];
  logic [1:0]  r_tag      [4];
  logic [3:0]  r_busy;
  logic [1:0]  r_out_resp [4];
  logic [31:0] r_out_data [4];
  logic [1:0]  r_out_tag  [4];

  logic [3:0]  w_pend;
  logic [3:0]  w_hit;
  logic        w_gnt_vld;
  logic [1:0]  w_gnt_idx;
  logic        w_take;

  iss_t        r_iss;
  logic [1:0]  r_cur;
  logic [3:0]  r_dn_cmd;
  logic [31:0] r_dn_data;
  logic [1:0]  r_dn_tag;
`ifndef CALC_ARB_FIXED_PRIORITY_EN
  logic [1:0]  r_ptr;
`endif

  assign w_req_cmd[0]  = req1_cmd_in;
  assign w_req_cmd[1]  = req2_cmd_in;
  assign w_req_cmd[2]  = req3_cmd_in;
  assign w_req_cmd[3]  = req4_cmd_in;
  assign w_req_data[0] = req1_data_in;
  assign w_req_data[1] = req2_data_in;
  assign w_req_data[2] = req3_data_in;
  assign w_req_data[3] = req4_data_in;
  assign w_req_tag[0]  = req1_tag_in;
  assign w_req_tag[1]  = req2_tag_in;
  assign w_req_tag[2]  = req3_tag_in;
  assign w_req_tag[3]  = req4_tag_in;

  always_comb begin
    for (int n = 0; n < 4; n++) begin
      w_pend[n] = (r_slot[n] == SLOT_PEND);
      w_hit[n]  = (dn_resp != 2'd0) && (dn_rtag == 2'(n)) && (r_slot[n] == SLOT_OUT);
    end
  end

  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = 2'd0;
`ifdef CALC_ARB_FIXED_PRIORITY_EN
    for (int i = 3; i >= 0; i--) begin
      if (w_pend[i]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = 2'(i);
      end
    end
`else
    // Search begins one past the last grant; offset 4 wraps back to the pointer itself.
    for (int k = 1; k <= 4; k++) begin
      if (!w_gnt_vld && w_pend[r_ptr + 2'(k)]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = r_ptr + 2'(k);
      end
    end
`endif
  end

  assign w_take = w_gnt_vld && ((r_iss == ISS_IDLE) || (r_iss == ISS_ISSUE2));

  always_comb begin
    for (int n = 0; n < 4; n++) begin
      w_slot_nxt[n] = r_slot[n];
      case (r_slot[n])
        SLOT_EMPTY: if (w_req_cmd[n] != 4'd0) w_slot_nxt[n] = SLOT_OP2;
        SLOT_OP2:   w_slot_nxt[n] = SLOT_PEND;
        SLOT_PEND:  if (w_take && (w_gnt_idx == 2'(n))) w_slot_nxt[n] = SLOT_OUT;
        SLOT_OUT:   if (w_hit[n]) w_slot_nxt[n] = SLOT_EMPTY;
        default:    w_slot_nxt[n] = SLOT_EMPTY;
      endcase
    end
  end

  always_ff @(posedge c_clk) begin
    for (int n = 0; n < 4; n++) begin
      if (reset) begin
        r_slot[n]     <= SLOT_EMPTY;
        r_busy[n]     <= 1'b0;
        r_out_resp[n] <= 2'd0;
        r_out_data[n] <= 32'd0;
        r_out_tag[n]  <= 2'd0;
      end else begin
        r_slot[n]     <= w_slot_nxt[n];
        r_busy[n]     <= (w_slot_nxt[n] != SLOT_EMPTY);
        r_out_resp[n] <= w_hit[n] ? dn_resp  : 2'd0;
        r_out_data[n] <= w_hit[n] ? dn_rdata : 32'd0;
        r_out_tag[n]  <= w_hit[n] ? r_tag[n] : 2'd0;
      end
      // Payload registers are only meaningful while the slot state says so.
      if ((r_slot[n] == SLOT_EMPTY) && (w_req_cmd[n] != 4'd0)) begin
        r_cmd[n] <= w_req_cmd[n];
        r_op1[n] <= w_req_data[n];
        r_tag[n] <= w_req_tag[n];
      end
      if (r_slot[n] == SLOT_OP2) r_op2[n] <= w_req_data[n];
    end
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      r_iss     <= ISS_IDLE;
      r_cur     <= 2'd0;
      r_dn_cmd  <= 4'd0;
      r_dn_data <= 32'd0;
      r_dn_tag  <= 2'd0;
`ifndef CALC_ARB_FIXED_PRIORITY_EN
      r_ptr     <= 2'd3;
`endif
    end else begin
      case (r_iss)
        ISS_ISSUE1: begin
          r_iss     <= ISS_ISSUE2;
          r_dn_cmd  <= 4'd0;
          r_dn_data <= r_op2[r_cur];
          r_dn_tag  <= r_cur;
        end
        default: begin
          if (w_take) begin
            r_iss     <= ISS_ISSUE1;
            r_cur     <= w_gnt_idx;
            r_dn_cmd  <= r_cmd[w_gnt_idx];
            r_dn_data <= r_op1[w_gnt_idx];
            r_dn_tag  <= w_gnt_idx;
`ifndef CALC_ARB_FIXED_PRIORITY_EN
            r_ptr     <= w_gnt_idx;
`endif
          end else begin
            r_iss     <= ISS_IDLE;
            r_dn_cmd  <= 4'd0;
            r_dn_data <= 32'd0;
            r_dn_tag  <= 2'd0;
          end
        end
      endcase
    end
  end

  assign port1_busy = r_busy[0];
  assign port2_busy = r_busy[1];
  assign port3_busy = r_busy[2];
  assign port4_busy = r_busy[3];
  assign out_resp1  = r_out_resp[0];
  assign out_resp2  = r_out_resp[1];
  assign out_resp3  = r_out_resp[2];
  assign out_resp4  = r_out_resp[3];
  assign out_data1  = r_out_data[0];
  assign out_data2  = r_out_data[1];
  assign out_data3  = r_out_data[2];
  assign out_data4  = r_out_data[3];
  assign out_tag1   = r_out_tag[0];
  assign out_tag2   = r_out_tag[1];
  assign out_tag3   = r_out_tag[2];
  assign out_tag4   = r_out_tag[3];
  assign dn_cmd     = r_dn_cmd;
  assign dn_data    = r_dn_data;
  assign dn_tag     = r_dn_tag;

endmodule
`default_nettype wire

// File: tb/tb_calc_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_calc_req_arbiter
// Description : Scoreboard bench for calc_req_arbiter (issue and response queues).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_calc_req_arbiter;

  logic        c_clk = 1'b0;
  logic        reset;
  logic [3:0]  req_cmd  [4];
  logic [31:0] req_data [4];
  logic [31:0] req_op2  [4];
  logic [1:0]  req_tag  [4];
  logic        port1_busy, port2_busy, port3_busy, port4_busy;
  logic [1:0]  out_resp1, out_resp2, out_resp3, out_resp4;
  logic [31:0] out_data1, out_data2, out_data3, out_data4;
  logic [1:0]  out_tag1, out_tag2, out_tag3, out_tag4;
  logic [3:0]  dn_cmd;
  logic [31:0] dn_data;
  logic [1:0]  dn_tag;
  logic [1:0]  dn_resp;
  logic [31:0] dn_rdata;
  logic [1:0]  dn_rtag;
  logic [3:0]  busy;
  logic [143:0] outs;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [1:0]  tag;
  } iss_t;

  iss_t         exp_iss[$];
  logic [143:0] exp_out[$];
  int           errors = 0;
  int           checks = 0;

  always #5 c_clk = ~c_clk;

  calc_req_arbiter dut (
    .c_clk(c_clk), .reset(reset),
    .req1_cmd_in(req_cmd[0]), .req2_cmd_in(req_cmd[1]),
    .req3_cmd_in(req_cmd[2]), .req4_cmd_in(req_cmd[3]),
    .req1_data_in(req_data[0]), .req2_data_in(req_data[1]),
    .req3_data_in(req_data[2]), .req4_data_in(req_data[3]),
    .req1_tag_in(req_tag[0]), .req2_tag_in(req_tag[1]),
    .req3_tag_in(req_tag[2]), .req4_tag_in(req_tag[3]),
    .port1_busy(port1_busy), .port2_busy(port2_busy),
    .port3_busy(port3_busy), .port4_busy(port4_busy),
    .out_resp1(out_resp1), .out_resp2(out_resp2), .out_resp3(out_resp3), .out_resp4(out_resp4),
    .out_data1(out_data1), .out_data2(out_data2), .out_data3(out_data3), .out_data4(out_data4),
    .out_tag1(out_tag1), .out_tag2(out_tag2), .out_tag3(out_tag3), .out_tag4(out_tag4),
    .dn_cmd(dn_cmd), .dn_data(dn_data), .dn_tag(dn_tag),
    .dn_resp(dn_resp), .dn_rdata(dn_rdata), .dn_rtag(dn_rtag)
  );

  assign busy = {port4_busy, port3_busy, port2_busy, port1_busy};
  assign outs = {out_resp4, out_data4, out_tag4, out_resp3, out_data3, out_tag3,
                 out_resp2, out_data2, out_tag2, out_resp1, out_data1, out_tag1};

  function automatic logic [143:0] outvec(input int p, input logic [1:0] r,
                                          input logic [31:0] d, input logic [1:0] t);
    logic [143:0] v;
    v = 144'({r, d, t});
    return v << (36 * p);
  endfunction

  task automatic clear_inputs();
    for (int i = 0; i < 4; i++) begin
      req_cmd[i] = 4'd0; req_data[i] = 32'd0; req_op2[i] = 32'd0; req_tag[i] = 2'd0;
    end
    dn_resp = 2'd0; dn_rdata = 32'd0; dn_rtag = 2'd0;
  endtask

  // Present a command on port p and record the issue it must produce.
  task automatic set_req(input int p, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [1:0] t);
    req_cmd[p] = c; req_data[p] = a; req_op2[p] = b; req_tag[p] = t;
    exp_iss.push_back('{cmd: c, op1: a, op2: b, tag: 2'(p)});
  endtask

  // Called just after a rising edge with commands set; drives the op2 beat.
  task automatic cmd_phase();
    @(posedge c_clk); #1;
    for (int i = 0; i < 4; i++) begin
      req_cmd[i] = 4'd0; req_data[i] = req_op2[i]; req_tag[i] = 2'd0;
    end
    @(posedge c_clk); #1;
    for (int i = 0; i < 4; i++) req_data[i] = 32'd0;
  endtask

  // Collect the next two-beat issue; lat = -1 when none appears within budget.
  task automatic wait_issue(input int budget, output int lat,
                            output logic [37:0] ph1, output logic [37:0] ph2);
    lat = -1; ph1 = '0; ph2 = '0;
    for (int i = 0; i < budget; i++) begin
      @(negedge c_clk);
      if (dn_cmd != 4'd0) begin
        lat = i; ph1 = {dn_cmd, dn_data, dn_tag};
        break;
      end
    end
    if (lat >= 0) begin
      @(negedge c_clk);
      ph2 = {dn_cmd, dn_data, dn_tag};
    end
  endtask

  // One-cycle downstream response; captures the cycle after it and the one after that.
  task automatic send_resp(input logic [1:0] r, input logic [31:0] d, input logic [1:0] t,
                           output logic [143:0] o1, output logic [143:0] o2,
                           output logic [3:0] b1);
    @(posedge c_clk); #1;
    dn_resp = r; dn_rdata = d; dn_rtag = t;
    @(posedge c_clk); #1;
    dn_resp = 2'd0; dn_rdata = 32'd0; dn_rtag = 2'd0;
    for (int i = 0; i < 4; i++) req_cmd[i] = 4'd0;
    @(negedge c_clk); o1 = outs; b1 = busy;
    @(negedge c_clk); o2 = outs;
  endtask

  task automatic pulse_reset();
    @(posedge c_clk); #1; reset = 1'b1;
    @(posedge c_clk); #1; reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    repeat (3) @(posedge c_clk);
    #1; reset = 1'b0;
    @(negedge c_clk);
    checks++; if (busy !== 4'd0) begin errors++; $display("FAIL reset_busy: got %b want 0000", busy); end
    checks++; if ({dn_cmd, dn_data, dn_tag} !== 38'd0) begin errors++;
      $display("FAIL reset_dn: got %h want 0", {dn_cmd, dn_data, dn_tag}); end
    checks++; if (outs !== 144'd0) begin errors++; $display("FAIL reset_out: got %h want 0", outs); end
  endtask

  task automatic test_single_add();
    int lat; logic [37:0] ph1, ph2; iss_t e; logic [143:0] o1, o2, ev; logic [3:0] b1;
    @(posedge c_clk); #1;
    set_req(0, 4'd1, 32'd5, 32'd7, 2'd2);
    cmd_phase();
    wait_issue(12, lat, ph1, ph2);
    e = exp_iss.pop_front();
    checks++; if (lat !== 1) begin errors++; $display("FAIL add_latency: got %0d want 1", lat); end
    checks++; if (ph1 !== {e.cmd, e.op1, e.tag}) begin errors++;
      $display("FAIL add_issue1: got %h want %h", ph1, {e.cmd, e.op1, e.tag}); end
    checks++; if (ph2 !== {4'd0, e.op2, e.tag}) begin errors++;
      $display("FAIL add_issue2: got %h want %h", ph2, {4'd0, e.op2, e.tag}); end
    checks++; if (busy !== 4'b0001) begin errors++; $display("FAIL add_busy: got %b want 0001", busy); end
    exp_out.push_back(outvec(0, 2'd1, 32'd12, 2'd2));
    send_resp(2'd1, 32'd12, 2'd0, o1, o2, b1);
    ev = exp_out.pop_front();
    checks++; if (o1 !== ev) begin errors++; $display("FAIL add_resp: got %h want %h", o1, ev); end
    checks++; if (o2 !== 144'd0) begin errors++; $display("FAIL add_resp_once: got %h want 0", o2); end
    checks++; if (b1 !== 4'd0) begin errors++; $display("FAIL add_busy_drop: got %b want 0000", b1); end
  endtask

  task automatic test_all_ports_ooo();
    int lat; logic [37:0] ph1, ph2; iss_t e; logic [143:0] o1, o2, ev; logic [3:0] b1;
    int order [4];
    logic [1:0] utag [4];
    order = '{3, 0, 1, 2};
    utag  = '{2'd3, 2'd1, 2'd0, 2'd2};
    pulse_reset();
    for (int p = 0; p < 4; p++)
      set_req(p, 4'(p + 2), 32'(16 * p + 1), 32'(16 * p + 9), utag[p]);
    cmd_phase();
    for (int i = 0; i < 4; i++) begin
      wait_issue(12, lat, ph1, ph2);
      e = exp_iss.pop_front();
      checks++; if (lat !== ((i == 0) ? 1 : 0)) begin errors++;
        $display("FAIL all_lat%0d: got %0d want %0d", i, lat, (i == 0) ? 1 : 0); end
      checks++; if (ph1 !== {e.cmd, e.op1, e.tag}) begin errors++;
        $display("FAIL all_issue1_%0d: got %h want %h", i, ph1, {e.cmd, e.op1, e.tag}); end
      checks++; if (ph2 !== {4'd0, e.op2, e.tag}) begin errors++;
        $display("FAIL all_issue2_%0d: got %h want %h", i, ph2, {4'd0, e.op2, e.tag}); end
    end
    for (int i = 0; i < 4; i++) begin
      exp_out.push_back(outvec(order[i], 2'(i % 3 + 1), 32'(1000 + i), utag[order[i]]));
      send_resp(2'(i % 3 + 1), 32'(1000 + i), 2'(order[i]), o1, o2, b1);
      ev = exp_out.pop_front();
      checks++; if (o1 !== ev) begin errors++; $display("FAIL ooo_resp%0d: got %h want %h", i, o1, ev); end
      checks++; if (o2 !== 144'd0) begin errors++; $display("FAIL ooo_once%0d: got %h want 0", i, o2); end
    end
  endtask

  task automatic test_rr_pointer();
    int lat; logic [37:0] ph1, ph2; iss_t e; logic [143:0] o1, o2, ev; logic [3:0] b1;
    @(posedge c_clk); #1;
    set_req(1, 4'd9, 32'd40, 32'd41, 2'd0);
    cmd_phase();
    wait_issue(12, lat, ph1, ph2);
    e = exp_iss.pop_front();
    checks++; if (ph1 !== {e.cmd, e.op1, e.tag}) begin errors++;
      $display("FAIL rr_single: got %h want %h", ph1, {e.cmd, e.op1, e.tag}); end
    send_resp(2'd1, 32'd0, 2'd1, o1, o2, b1);
    // Last grant was port 2: round-robin favours port 3, fixed priority favours port 1.
    @(posedge c_clk); #1;
`ifdef CALC_ARB_FIXED_PRIORITY_EN
    set_req(0, 4'd3, 32'd50, 32'd51, 2'd1);
    set_req(2, 4'd4, 32'd60, 32'd61, 2'd2);
`else
    set_req(2, 4'd4, 32'd60, 32'd61, 2'd2);
    set_req(0, 4'd3, 32'd50, 32'd51, 2'd1);
`endif
    cmd_phase();
    for (int i = 0; i < 2; i++) begin
      wait_issue(12, lat, ph1, ph2);
      e = exp_iss.pop_front();
      checks++; if (ph1 !== {e.cmd, e.op1, e.tag}) begin errors++;
        $display("FAIL rr_order%0d: got %h want %h", i, ph1, {e.cmd, e.op1, e.tag}); end
      checks++; if (ph2 !== {4'd0, e.op2, e.tag}) begin errors++;
        $display("FAIL rr_op2_%0d: got %h want %h", i, ph2, {4'd0, e.op2, e.tag}); end
    end
    exp_out.push_back(outvec(2, 2'd2, 32'd77, 2'd2));
    send_resp(2'd2, 32'd77, 2'd2, o1, o2, b1);
    ev = exp_out.pop_front();
    checks++; if (o1 !== ev) begin errors++; $display("FAIL rr_resp3: got %h want %h", o1, ev); end
    exp_out.push_back(outvec(0, 2'd1, 32'd88, 2'd1));
    send_resp(2'd1, 32'd88, 2'd0, o1, o2, b1);
    ev = exp_out.pop_front();
    checks++; if (o1 !== ev) begin errors++; $display("FAIL rr_resp1: got %h want %h", o1, ev); end
  endtask

  task automatic test_busy_drop();
    int lat; logic [37:0] ph1, ph2; iss_t e; logic [143:0] o1, o2, ev; logic [3:0] b1;
    @(posedge c_clk); #1;
    set_req(1, 4'd2, 32'd100, 32'd200, 2'd1);
    @(posedge c_clk); #1;
    req_cmd[1] = 4'd3; req_data[1] = 32'd200; req_tag[1] = 2'd3;
    @(negedge c_clk);
    checks++; if (busy !== 4'b0010) begin errors++; $display("FAIL drop_busy: got %b want 0010", busy); end
    @(posedge c_clk); #1;
    req_cmd[1] = 4'd0; req_data[1] = 32'd0; req_tag[1] = 2'd0;
    wait_issue(12, lat, ph1, ph2);
    e = exp_iss.pop_front();
    checks++; if (ph1 !== {e.cmd, e.op1, e.tag}) begin errors++;
      $display("FAIL drop_issue1: got %h want %h", ph1, {e.cmd, e.op1, e.tag}); end
    checks++; if (ph2 !== {4'd0, e.op2, e.tag}) begin errors++;
      $display("FAIL drop_issue2: got %h want %h", ph2, {4'd0, e.op2, e.tag}); end
    @(posedge c_clk); #1;
    req_cmd[1] = 4'd4; req_data[1] = 32'd1;
    @(posedge c_clk); #1;
    req_cmd[1] = 4'd0; req_data[1] = 32'd0;
    wait_issue(8, lat, ph1, ph2);
    checks++; if (lat !== -1) begin errors++; $display("FAIL drop_no_issue: got issue %h want none", ph1); end
    req_cmd[1] = 4'd5;
    exp_out.push_back(outvec(1, 2'd3, 32'd300, 2'd1));
    send_resp(2'd3, 32'd300, 2'd1, o1, o2, b1);
    ev = exp_out.pop_front();
    checks++; if (o1 !== ev) begin errors++; $display("FAIL drop_resp: got %h want %h", o1, ev); end
    checks++; if (o2 !== 144'd0) begin errors++; $display("FAIL drop_extra_resp: got %h want 0", o2); end
    checks++; if (b1 !== 4'd0) begin errors++; $display("FAIL drop_same_edge_busy: got %b want 0000", b1); end
    wait_issue(8, lat, ph1, ph2);
    checks++; if (lat !== -1) begin errors++; $display("FAIL drop_same_edge_issue: got %h want none", ph1); end
  endtask

  task automatic test_reset_mid_issue();
    int lat; logic [37:0] ph1, ph2; iss_t e; logic [143:0] o1, o2, ev; logic [3:0] b1;
    @(posedge c_clk); #1;
    set_req(0, 4'd6, 32'd11, 32'd22, 2'd3);
    cmd_phase();
    @(posedge c_clk); #1;
    reset = 1'b1;
    @(negedge c_clk);
    e = exp_iss.pop_front();
    checks++; if ({dn_cmd, dn_data, dn_tag} !== {e.cmd, e.op1, e.tag}) begin errors++;
      $display("FAIL rstmid_issue1: got %h want %h", {dn_cmd, dn_data, dn_tag}, {e.cmd, e.op1, e.tag}); end
    @(posedge c_clk); #1;
    reset = 1'b0;
    @(negedge c_clk);
    checks++; if (busy !== 4'd0) begin errors++; $display("FAIL rstmid_busy: got %b want 0000", busy); end
    checks++; if ({dn_cmd, dn_data, dn_tag} !== 38'd0) begin errors++;
      $display("FAIL rstmid_dn: got %h want 0", {dn_cmd, dn_data, dn_tag}); end
    checks++; if (outs !== 144'd0) begin errors++; $display("FAIL rstmid_out: got %h want 0", outs); end
    exp_out.push_back(144'd0);
    send_resp(2'd1, 32'd99, 2'd0, o1, o2, b1);
    ev = exp_out.pop_front();
    checks++; if (o1 !== ev) begin errors++; $display("FAIL rstmid_late_resp: got %h want %h", o1, ev); end
    checks++; if (b1 !== 4'd0) begin errors++; $display("FAIL rstmid_late_busy: got %b want 0000", b1); end
    wait_issue(6, lat, ph1, ph2);
    checks++; if (lat !== -1) begin errors++; $display("FAIL rstmid_reissue: got %h want none", ph1); end
  endtask

  task automatic test_stray_response();
    int lat; logic [37:0] ph1, ph2; iss_t e; logic [143:0] o1, o2, ev; logic [3:0] b1;
    @(posedge c_clk); #1;
    set_req(0, 4'd7, 32'd3, 32'd4, 2'd1);
    cmd_phase();
    wait_issue(12, lat, ph1, ph2);
    e = exp_iss.pop_front();
    checks++; if (ph1 !== {e.cmd, e.op1, e.tag}) begin errors++;
      $display("FAIL stray_issue: got %h want %h", ph1, {e.cmd, e.op1, e.tag}); end
    exp_out.push_back(144'd0);
    send_resp(2'd1, 32'd55, 2'd2, o1, o2, b1);
    ev = exp_out.pop_front();
    checks++; if (o1 !== ev) begin errors++; $display("FAIL stray_resp: got %h want %h", o1, ev); end
    checks++; if (b1 !== 4'b0001) begin errors++; $display("FAIL stray_busy: got %b want 0001", b1); end
    exp_out.push_back(outvec(0, 2'd1, 32'd7, 2'd1));
    send_resp(2'd1, 32'd7, 2'd0, o1, o2, b1);
    ev = exp_out.pop_front();
    checks++; if (o1 !== ev) begin errors++; $display("FAIL stray_after_resp: got %h want %h", o1, ev); end
    checks++; if (b1 !== 4'd0) begin errors++; $display("FAIL stray_after_busy: got %b want 0000", b1); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_add();
    test_all_ports_ooo();
    test_rr_pointer();
    test_busy_drop();
    test_reset_mid_issue();
    test_stray_response();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
